// File: rtl/txs_burst_slave_mem_if.sv
// Avalon-MM TXS burst bus between the PCIe TXS initiator and a burst slave.
// The master drives commands and write beats; the slave returns wait-request and read data.
interface txs_burst_slave_mem_if;
  logic        txs_chip_select;
  logic        txs_read;
  logic        txs_write;
  logic [31:0] txs_address;
  logic [9:0]  txs_burst_count;
  logic [31:0] txs_writedata;
  logic [3:0]  txs_byteenable;
  logic        txs_wait_request;
  logic        txs_read_valid;
  logic [31:0] txs_readdata;

  modport master (
    output txs_chip_select, txs_read, txs_write, txs_address,
           txs_burst_count, txs_writedata, txs_byteenable,
    input  txs_wait_request, txs_read_valid, txs_readdata
  );

  modport slave (
    input  txs_chip_select, txs_read, txs_write, txs_address,
           txs_burst_count, txs_writedata, txs_byteenable,
    output txs_wait_request, txs_read_valid, txs_readdata
  );
endinterface

// File: rtl/txs_burst_slave_mem.sv
// Avalon-MM burst slave backed by an on-chip word RAM, with a programmable
// wait-request stall generator for exercising initiator backpressure.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | ready for a command or first write beat (stalls only)
//   S_WR     | mid write burst, accepting beats until beat_count hits 0
//   S_RD_LAT | one cycle for the synchronous RAM read of the first word
//   S_RD     | streaming read beats gap-free, then one cycle to drain
module txs_burst_slave_mem #(
  parameter int ADDR_BITS   = 9,
  parameter int MAX_BURST   = 512,
  parameter int STALL_EVERY = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  txs_burst_slave_mem_if.slave txs,
  output logic                 protocol_err,
  output logic [9:0]           beat_count
);
  localparam int                   DEPTH      = 2 ** ADDR_BITS;
  localparam logic [9:0]           MAX_BC     = 10'(MAX_BURST);
  localparam logic [15:0]          STALL_LAST = (STALL_EVERY > 0) ? 16'(STALL_EVERY - 1) : 16'd0;
  localparam logic [ADDR_BITS-1:0] ONE_W      = 1;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_LAT, S_RD} state_t;
  state_t state, state_nxt;

  logic [31:0]          mem [DEPTH];
  logic [31:0]          ram_q;
  logic [31:0]          readdata;
  logic                 read_valid, read_valid_nxt;
  logic [ADDR_BITS-1:0] addr, addr_nxt, cmd_idx, wr_idx;
  logic [9:0]           beat_count_nxt, bc_eff;
  logic                 bc_bad, err_nxt;
  logic [15:0]          stall_cnt;
  logic                 stall_now, wait_request;
  logic                 acc_wr, acc_rd, mem_we;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{txs.txs_address[31:ADDR_BITS+2], txs.txs_address[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    stall_cnt <= '0;
    else if (stall_cnt == STALL_LAST) stall_cnt <= '0;
    else                              stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_now = (STALL_EVERY > 0) && (stall_cnt == STALL_LAST);

  // Held high through reset so the master cannot hand us a beat while we are down.
  assign wait_request = !reset_n || (state == S_RD_LAT) || (state == S_RD) || stall_now;

  assign cmd_idx = txs.txs_address[ADDR_BITS+1:2];
  assign bc_bad  = (txs.txs_burst_count == 10'd0) || (txs.txs_burst_count > MAX_BC);
  assign bc_eff  = bc_bad ? 10'd1 : txs.txs_burst_count;
  assign acc_wr  = txs.txs_chip_select && txs.txs_write && !wait_request;
  assign acc_rd  = txs.txs_chip_select && txs.txs_read  && !wait_request;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    beat_count_nxt = beat_count;
    err_nxt        = protocol_err;
    read_valid_nxt = 1'b0;
    mem_we         = 1'b0;
    wr_idx         = addr;
    unique case (state)
      S_IDLE: begin
        wr_idx = cmd_idx;
        if (acc_wr) begin
          mem_we   = 1'b1;
          addr_nxt = cmd_idx + ONE_W;
          if (bc_bad || txs.txs_read) err_nxt = 1'b1;
          if (bc_eff != 10'd1) begin
            beat_count_nxt = bc_eff - 10'd1;
            state_nxt      = S_WR;
          end
        end else if (acc_rd) begin
          addr_nxt       = cmd_idx;
          beat_count_nxt = bc_eff;
          state_nxt      = S_RD_LAT;
          if (bc_bad) err_nxt = 1'b1;
        end
      end
      S_WR: begin
        if (acc_wr) begin
          mem_we         = 1'b1;
          addr_nxt       = addr + ONE_W;
          beat_count_nxt = beat_count - 10'd1;
          if (beat_count == 10'd1) state_nxt = S_IDLE;
        end
      end
      S_RD_LAT: begin
        addr_nxt  = addr + ONE_W;
        state_nxt = S_RD;
      end
      S_RD: begin
        // ram_q always holds the word for the next beat; addr runs one word ahead.
        addr_nxt = addr + ONE_W;
        if (beat_count != 10'd0) begin
          read_valid_nxt = 1'b1;
          beat_count_nxt = beat_count - 10'd1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr         <= '0;
      beat_count   <= '0;
      protocol_err <= 1'b0;
      read_valid   <= 1'b0;
      readdata     <= '0;
    end else begin
      addr         <= addr_nxt;
      beat_count   <= beat_count_nxt;
      protocol_err <= err_nxt;
      read_valid   <= read_valid_nxt;
      if (read_valid_nxt) readdata <= ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (txs.txs_byteenable[i]) mem[wr_idx][8*i +: 8] <= txs.txs_writedata[8*i +: 8];
    end
    ram_q <= mem[addr];
  end

  assign txs.txs_wait_request = wait_request;
  assign txs.txs_read_valid   = read_valid;
  assign txs.txs_readdata     = readdata;
endmodule
